// File: rtl/player_ctrl_gen.sv
// player_ctrl_gen: per-player move/collide/lives/bomb control over one map read port (PLAYER_SLIDE_EN adds corner slide)
module player_ctrl_gen #(
    parameter int TILE_LOG2 = 5,
    parameter int MAP_W = 20,
    parameter int NUM_BLAST = 10,
    parameter int MAX_LIVES = 3,
    parameter int SPAWN_X = 550,
    parameter int SPAWN_Y = 419,
    parameter int X_MIN = 32,
    parameter int X_MAX = 575,
    parameter int Y_MIN = 32,
    parameter int Y_MAX = 447,
    parameter int SPR_W = 20,
    parameter int SPR_H = 27,
    parameter int INVULN_FRAMES = 60,
    parameter logic [7:0] KEY_UP = 8'h52,
    parameter logic [7:0] KEY_DOWN = 8'h51,
    parameter logic [7:0] KEY_LEFT = 8'h50,
    parameter logic [7:0] KEY_RIGHT = 8'h4F,
    parameter logic [7:0] KEY_BOMB = 8'h13
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_tick,
    input  logic                    enable,
    input  logic [7:0]              keycode,
    input  logic                    speed_pu,
    input  logic                    lives_pu,
    input  logic [NUM_BLAST*10-1:0] blast_addr,
    input  logic [NUM_BLAST-1:0]    blast_valid,
    output logic [9:0]              map_addr,
    output logic                    map_rd,
    input  logic [3:0]              map_q,
    output logic [9:0]              userX,
    output logic [9:0]              userY,
    output logic                    bomb_drop,
    output logic                    hit,
    output logic [2:0]              live_count,
    output logic                    collide
);
    localparam int TILE = 1 << TILE_LOG2;
    localparam int IW = $clog2(INVULN_FRAMES + 2);

    typedef enum logic [1:0] {IDLE, PROBE, DECIDE, DEAD} state_t;
    state_t state, next_state;

    logic [9:0] cand_x, cand_y;
    logic [2:0] pc;
    logic [3:0] solid;
    logic [7:0] prev_key;
    logic [IW-1:0] invuln;
    logic [10:0] step, nx, ny;
    logic [9:0] c_tl, c_tr, c_bl, c_br;
    logic is_dir, in_bounds, blast_any, tick_go, lose, start;

    function automatic logic [9:0] tile_of(input logic [9:0] x, input logic [9:0] y);
        logic [19:0] t;
        t = 20'(y >> TILE_LOG2) * 20'(MAP_W) + 20'(x >> TILE_LOG2);
        return t[9:0];
    endfunction

    always_comb begin
        step = speed_pu ? 11'd2 : 11'd1;
        nx = keycode == KEY_LEFT ? {1'b0, userX} - step : keycode == KEY_RIGHT ? {1'b0, userX} + step : {1'b0, userX};
        ny = keycode == KEY_UP ? {1'b0, userY} - step : keycode == KEY_DOWN ? {1'b0, userY} + step : {1'b0, userY};
        is_dir = keycode == KEY_UP || keycode == KEY_DOWN || keycode == KEY_LEFT || keycode == KEY_RIGHT;
        in_bounds = nx >= 11'(X_MIN) && nx <= 11'(X_MAX - SPR_W) && ny >= 11'(Y_MIN) && ny <= 11'(Y_MAX - SPR_H);
        c_tl = tile_of(userX, userY);
        c_tr = tile_of(userX + 10'(SPR_W), userY);
        c_bl = tile_of(userX, userY + 10'(SPR_H));
        c_br = tile_of(userX + 10'(SPR_W), userY + 10'(SPR_H));
        blast_any = 1'b0;
        for (int i = 0; i < NUM_BLAST; i++)
            blast_any = blast_any | (blast_valid[i] && (blast_addr[10*i +: 10] == c_tl || blast_addr[10*i +: 10] == c_tr || blast_addr[10*i +: 10] == c_bl || blast_addr[10*i +: 10] == c_br));
        tick_go = state == IDLE && frame_tick && enable;
        lose = tick_go && blast_any && invuln == '0;
        start = tick_go && !(blast_any && invuln == '0) && is_dir && in_bounds;
    end

`ifdef PLAYER_SLIDE_EN
    logic [1:0] dir, ndir;
    logic vert, la, lb, slide_ok;
    logic [9:0] p, ov;
    always_comb begin
        ndir = keycode == KEY_UP ? 2'd0 : keycode == KEY_DOWN ? 2'd1 : keycode == KEY_LEFT ? 2'd2 : 2'd3;
        vert = !dir[1];
        la = vert ? (dir[0] ? solid[2] : solid[0]) : (dir[0] ? solid[1] : solid[0]);
        lb = vert ? (dir[0] ? solid[3] : solid[1]) : (dir[0] ? solid[3] : solid[2]);
        p = vert ? userX : userY;
        // overlap with the open tile: high-side tile when the low-side corner is blocked
        ov = la ? ((p + 10'(vert ? SPR_W : SPR_H)) & 10'(TILE - 1)) + 10'd1 : 10'(TILE) - (p & 10'(TILE - 1));
        slide_ok = (la ^ lb) && ov >= 10'(TILE - 4);
    end
    always_ff @(posedge Clk) begin
        if (Reset) dir <= 2'd0;
        else if (start) dir <= ndir;
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else state <= next_state;
    end

    always_comb begin
        next_state = state == DEAD ? DEAD :
                     state == DECIDE ? IDLE :
                     state == PROBE ? (pc == 3'd4 ? DECIDE : PROBE) :
                     (lose && !lives_pu && live_count == 3'd1) ? DEAD :
                     start ? PROBE : IDLE;
    end

    always_comb begin
        map_rd = state == PROBE && pc != 3'd4;
        map_addr = !map_rd ? 10'd0 :
                   pc == 3'd0 ? tile_of(cand_x, cand_y) :
                   pc == 3'd1 ? tile_of(cand_x + 10'(SPR_W), cand_y) :
                   pc == 3'd2 ? tile_of(cand_x, cand_y + 10'(SPR_H)) :
                   tile_of(cand_x + 10'(SPR_W), cand_y + 10'(SPR_H));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            userX <= 10'(SPAWN_X);
            userY <= 10'(SPAWN_Y);
            live_count <= 3'(MAX_LIVES);
            invuln <= '0;
            collide <= 1'b0;
            hit <= 1'b0;
            bomb_drop <= 1'b0;
            prev_key <= 8'd0;
            cand_x <= 10'd0;
            cand_y <= 10'd0;
            pc <= 3'd0;
            solid <= 4'd0;
        end else begin
            hit <= lose;
            bomb_drop <= state != DEAD && frame_tick && enable && keycode == KEY_BOMB && prev_key != KEY_BOMB;
            if (state != DEAD && frame_tick) prev_key <= keycode;
            if (lose) invuln <= IW'(INVULN_FRAMES);
            else if (frame_tick && enable && invuln != '0) invuln <= invuln - 1'b1;
            if (start) begin
                cand_x <= nx[9:0];
                cand_y <= ny[9:0];
                pc <= 3'd0;
            end
            // responses trail their address by one cycle; shift TL..BR into bits 0..3
            if (state == PROBE) begin
                pc <= pc + 3'd1;
                if (pc != 3'd0) solid <= {map_q == 4'd1 || map_q == 4'd2, solid[3:1]};
            end
            if (state == DECIDE && enable) begin
                if (solid == 4'd0) begin
                    userX <= cand_x;
                    userY <= cand_y;
                end
`ifdef PLAYER_SLIDE_EN
                else if (slide_ok) begin
                    userX <= vert ? (la ? userX + 10'd1 : userX - 10'd1) : userX;
                    userY <= vert ? userY : (la ? userY + 10'd1 : userY - 10'd1);
                end
`endif
            end
            if (state != DEAD) begin
                if (lose && !lives_pu) begin
                    live_count <= live_count - 3'd1;
                    if (live_count == 3'd1) collide <= 1'b1;
                    else begin
                        userX <= 10'(SPAWN_X);
                        userY <= 10'(SPAWN_Y);
                    end
                end else if (lives_pu && !lose && live_count < 3'(MAX_LIVES)) begin
                    live_count <= live_count + 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_player_ctrl_gen.sv
// tb_player_ctrl_gen: directed bench for player_ctrl_gen with a registered map memory model
module tb_player_ctrl_gen;
    logic clk = 1'b0;
    logic rst, frame_tick, enable, speed_pu, lives_pu;
    logic [7:0] keycode;
    logic [99:0] blast_addr;
    logic [9:0] blast_valid;
    logic [9:0] map_addr, userX, userY;
    logic map_rd, bomb_drop, hit, collide;
    logic [3:0] map_q = 4'd0;
    logic [2:0] live_count;
    logic [3:0] mem [0:1023];
    int n_cmp = 0, n_bad = 0, bomb_cnt = 0, hit_cnt = 0;

    player_ctrl_gen dut (
        .Clk(clk), .Reset(rst), .frame_tick(frame_tick), .enable(enable), .keycode(keycode),
        .speed_pu(speed_pu), .lives_pu(lives_pu), .blast_addr(blast_addr), .blast_valid(blast_valid),
        .map_addr(map_addr), .map_rd(map_rd), .map_q(map_q), .userX(userX), .userY(userY),
        .bomb_drop(bomb_drop), .hit(hit), .live_count(live_count), .collide(collide)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (map_rd) map_q <= mem[map_addr];

    always @(negedge clk) begin
        if (bomb_drop) bomb_cnt++;
        if (hit) hit_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int gap, input logic pu);
        @(negedge clk);
        frame_tick = 1'b1;
        lives_pu = pu;
        @(negedge clk);
        frame_tick = 1'b0;
        lives_pu = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic probe_chk(input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2, input logic [9:0] a3);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("rd_p0", map_rd, 1);
        chk("addr_tl", map_addr, a0);
        @(negedge clk);
        chk("rd_p1", map_rd, 1);
        chk("addr_tr", map_addr, a1);
        @(negedge clk);
        chk("rd_p2", map_rd, 1);
        chk("addr_bl", map_addr, a2);
        @(negedge clk);
        chk("rd_p3", map_rd, 1);
        chk("addr_br", map_addr, a3);
        @(negedge clk);
        chk("rd_off", map_rd, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic pu_pulse();
        @(negedge clk);
        lives_pu = 1'b1;
        @(negedge clk);
        lives_pu = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 4'd0;
        rst = 1'b1;
        frame_tick = 1'b0;
        enable = 1'b1;
        keycode = 8'h00;
        speed_pu = 1'b0;
        lives_pu = 1'b0;
        blast_addr = '0;
        blast_valid = '0;
        repeat (3) @(negedge clk);
        chk("rst_x", userX, 550);
        chk("rst_y", userY, 419);
        chk("rst_lives", live_count, 3);
        chk("rst_collide", collide, 0);
        chk("rst_hit", hit, 0);
        chk("rst_bomb", bomb_drop, 0);
        chk("rst_rd", map_rd, 0);
        chk("rst_addr", map_addr, 0);
        rst = 1'b0;
        enable = 1'b0;
        keycode = 8'h50;
        tick(9, 0);
        chk("disabled_x", userX, 550);
        enable = 1'b1;
        probe_chk(10'd277, 10'd277, 10'd277, 10'd277);
        chk("left1_x", userX, 549);
        tick(9, 0);
        tick(9, 0);
        chk("left3_x", userX, 547);
        chk("left3_y", userY, 419);
        keycode = 8'h13;
        repeat (5) tick(9, 0);
        chk("bomb_hold", bomb_cnt, 1);
        chk("bomb_nomove", userX, 547);
        keycode = 8'h00;
        tick(9, 0);
        keycode = 8'h13;
        tick(9, 0);
        chk("bomb_again", bomb_cnt, 2);
        keycode = 8'h52;
        speed_pu = 1'b1;
        repeat (193) tick(7, 0);
        chk("up_y33", userY, 33);
        tick(9, 0);
        chk("oob_y33", userY, 33);
        speed_pu = 1'b0;
        keycode = 8'h51;
        tick(9, 0);
        chk("down_y34", userY, 34);
        speed_pu = 1'b1;
        keycode = 8'h52;
        tick(9, 0);
        chk("edge_y32", userY, 32);
        speed_pu = 1'b0;
        tick(9, 0);
        chk("oob_y32", userY, 32);
        speed_pu = 1'b1;
        keycode = 8'h51;
        repeat (19) tick(7, 0);
        keycode = 8'h50;
        repeat (235) tick(7, 0);
        speed_pu = 1'b0;
        tick(9, 0);
        chk("at_x76", userX, 76);
        chk("at_y70", userY, 70);
        mem[42] = 4'd3;
        mem[43] = 4'd1;
        mem[62] = 4'd4;
        mem[63] = 4'd2;
        keycode = 8'h4F;
        probe_chk(10'd42, 10'd43, 10'd62, 10'd63);
        chk("blocked_x", userX, 76);
        keycode = 8'h50;
        tick(9, 0);
        chk("open34_x", userX, 75);
        keycode = 8'h00;
        blast_addr[39:30] = 10'd42;
        blast_valid = 10'b00_0000_1000;
        tick(9, 0);
        chk("hit1_cnt", hit_cnt, 1);
        chk("hit1_lives", live_count, 2);
        chk("hit1_x", userX, 550);
        chk("hit1_y", userY, 419);
        blast_addr[39:30] = 10'd277;
        repeat (60) tick(7, 0);
        chk("immune_cnt", hit_cnt, 1);
        chk("immune_lives", live_count, 2);
        pu_pulse();
        chk("pu_inc", live_count, 3);
        pu_pulse();
        chk("pu_sat", live_count, 3);
        tick(9, 0);
        chk("hit2_cnt", hit_cnt, 2);
        chk("hit2_lives", live_count, 2);
        repeat (60) tick(7, 0);
        tick(9, 1);
        chk("hit3pu_cnt", hit_cnt, 3);
        chk("hit3pu_lives", live_count, 2);
        repeat (60) tick(7, 0);
        tick(9, 0);
        chk("hit4_cnt", hit_cnt, 4);
        chk("hit4_lives", live_count, 1);
        chk("hit4_collide", collide, 0);
        repeat (60) tick(7, 0);
        tick(9, 0);
        chk("hit5_cnt", hit_cnt, 5);
        chk("dead_lives", live_count, 0);
        chk("dead_collide", collide, 1);
        pu_pulse();
        chk("dead_pu", live_count, 0);
        keycode = 8'h50;
        tick(9, 0);
        chk("dead_x", userX, 550);
        chk("dead_rd", map_rd, 0);
        keycode = 8'h13;
        tick(9, 0);
        chk("dead_bomb", bomb_cnt, 2);
        repeat (61) tick(7, 0);
        chk("dead_nohit", hit_cnt, 5);
        chk("dead_sticky", collide, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rerst_lives", live_count, 3);
        chk("rerst_collide", collide, 0);
        chk("rerst_x", userX, 550);
        rst = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/player_ctrl_gen.md
Name: player_ctrl_gen

Overview:
Parametrised per-player movement, collision and lives controller for the Bomberman game; one instance per player.
- Replaces the fixed four-RAM, frame-clocked player block with a single map read port sequenced over four corners, all in the Clk domain.
- Keys, sprite size, arena bounds, spawn point, blast-slot count and life count are configurable.
- Adds respawn invulnerability and a saturating lives power-up.

Parameters:
TILE_LOG2, 5, log2 of tile edge in pixels (32 px tiles)
MAP_W, 20, tiles per map row
NUM_BLAST, 10, number of blast tile slots checked
MAX_LIVES, 3, starting and maximum lives (must be 1..7)
SPAWN_X, 550, reset/respawn X pixel
SPAWN_Y, 419, reset/respawn Y pixel
X_MIN, 32 / X_MAX, 575 / Y_MIN, 32 / Y_MAX, 447, arena pixel bounds
SPR_W, 20 / SPR_H, 27, sprite bounding box offsets
INVULN_FRAMES, 60, frames of blast immunity after respawn
KEY_UP 8'h52, KEY_DOWN 8'h51, KEY_LEFT 8'h50, KEY_RIGHT 8'h4F, KEY_BOMB 8'h13, keycodes

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-Clk pulse per video frame
enable  in  1  game in play state
keycode  in  8  current key for this player
speed_pu  in  1  level: step 2 px instead of 1
lives_pu  in  1  one-Clk pulse: +1 life
blast_addr  in  NUM_BLAST*10  flattened blast tile indices, slot i at [10i+9:10i]
blast_valid  in  NUM_BLAST  per-slot valid
map_addr  out  10  map tile index being read
map_rd  out  1  read strobe
map_q  in  4  tile data, valid exactly 1 Clk after map_rd
userX, userY  out  10  sprite top-left pixel
bomb_drop  out  1  one-Clk pulse
hit  out  1  one-Clk pulse on life lost
live_count  out  3  remaining lives
collide  out  1  sticky game-over

Behaviour:
- Reset values: userX=SPAWN_X, userY=SPAWN_Y, live_count=MAX_LIVES, invuln counter=0, collide=0, hit=0, bomb_drop=0, map_rd=0, map_addr=0, state=IDLE. Reset overrides every event in the same cycle.
- Tile index = (y>>TILE_LOG2)*MAP_W + (x>>TILE_LOG2), truncated to 10 bits. Corners: TL (x,y), TR (x+SPR_W,y), BL (x,y+SPR_H), BR (x+SPR_W,y+SPR_H).
- FSM states: IDLE, PROBE, DECIDE, DEAD.
- IDLE, on frame_tick with enable=1:
  - Blast check first: any valid slot matches any corner of the current position and invuln=0 -> lose life; no move.
  - Otherwise latch direction from keycode and step (speed_pu ? 2 : 1).
  - Candidate position = current ± step on one axis. Non-direction key, or candidate outside [X_MIN, X_MAX-SPR_W] x [Y_MIN, Y_MAX-SPR_H] -> stay in IDLE, no move.
  - Else -> PROBE.
- PROBE: 4 consecutive cycles, map_rd=1, map_addr = candidate TL, TR, BL, BR in that order. Each response is sampled the following cycle. A corner is solid if map_q is 1 or 2.
- DECIDE (cycle after the last response): no solid corner and enable still 1 -> commit candidate; else discard. -> IDLE. Tick-to-commit latency is 6 Clk.
- frame_tick outside IDLE is ignored. Required tick spacing ≥ 7 Clk.
- Invuln counter decrements on each frame_tick with enable=1 while nonzero; it holds while enable=0.
- Lose life:
  - hit pulses for 1 Clk and live_count decrements.
  - If the result is 0 -> DEAD with collide=1, position frozen.
  - Else position=SPAWN and invuln=INVULN_FRAMES.
- lives_pu: +1 in any non-DEAD cycle, saturating at MAX_LIVES. Coincident with a life loss -> net unchanged, no respawn, but hit still pulses and invuln still loads.
- bomb_drop: pulses on a frame_tick when keycode==KEY_BOMB and keycode at the previous tick was not KEY_BOMB; requires enable=1 and state not DEAD. It is independent of movement, so a bomb key never moves the sprite.
- DEAD: all inputs ignored until Reset; map_rd=0.

Optional Feature:
PLAYER_SLIDE_EN: when a move is blocked by exactly one leading corner and the sprite overlaps the open tile by ≥ TILE-4 px on the perpendicular axis, DECIDE commits a 1 px perpendicular nudge toward the open tile instead of discarding. Without the macro, a blocked move is always discarded.

Test Plan:
- Reset, enable=1, keycode=8'h50, map all 0, 3 ticks 10 Clk apart -> userX=547, userY=419, map_rd high 4 Clk per tick, addresses TL, TR, BL, BR.
- At (64,64), keycode=8'h4F, map_q=1 on the TR/BR tile -> userX stays 64 after DECIDE.
- blast_valid[3]=1, blast_addr slot 3 = TL tile, tick -> hit pulse, live_count 3->2, position=SPAWN; second blast within 60 ticks -> no hit.
- Three blast hits spaced >60 ticks -> live_count=0, collide=1 sticky; lives_pu then ignored; Reset restores 3.
- Hold keycode=8'h13 for 5 ticks -> exactly one bomb_drop pulse; release and press again -> second pulse.
- speed_pu=1, keycode=8'h52 at Y_MIN+1 -> no move (candidate out of bounds); at Y_MIN+2 -> userY=Y_MIN.
